// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Conditions NKEYS raw, bouncing, asynchronous key switches into
//            clean debounced levels. It also produces one-cycle press and
//            release pulses, a lowest-index key code, and valid and
//            multi-key flags.
// Revision : 1.0  initial release
// ============================================================================
module key_debounce #(
  parameter int NKEYS        = 8,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int CNT_W        = 15
) (
  input  logic                       clk,
  input  logic                       rst,          // asynchronous, active-low
  input  logic [NKEYS-1:0]           key_raw,
  output logic [NKEYS-1:0]           key_stable,
  output logic [NKEYS-1:0]           key_press,
  output logic [NKEYS-1:0]           key_release,
  output logic                       key_valid,
  output logic [$clog2(NKEYS)-1:0]   key_code,
  output logic                       multi_key
);

  localparam int              CODE_W   = $clog2(NKEYS);
  // Terminal count: the mismatch has been seen long enough to accept it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [NKEYS-1:0] sync1_q, sync1_d;
  logic [NKEYS-1:0] sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q [NKEYS];
  logic [CNT_W-1:0] cnt_d [NKEYS];
  logic [NKEYS-1:0] key_stable_q, key_stable_d;
  logic [NKEYS-1:0] key_press_q, key_press_d;
  logic [NKEYS-1:0] key_release_q, key_release_d;
  logic [CODE_W-1:0] code_w;

  // Two-flop synchroniser chain for the asynchronous switch levels.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
  end

  // Per-key stability counter. Any agreement with the accepted level restarts
  // the count, so a bounce that returns within the window leaves no trace.
  always_comb begin
    key_stable_d = key_stable_q;
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != key_stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          key_stable_d[i] = sync2_q[i];
          cnt_d[i]        = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge pulses are registered alongside the level, so they appear in the cycle
  // where the new stable level first shows.
  always_comb begin
    key_press_d   = key_stable_d & ~key_stable_q;
    key_release_d = ~key_stable_d & key_stable_q;
  end

  // State registers. Reset clears everything, including any in-flight counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      key_stable_q  <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      key_stable_q  <= key_stable_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Priority encoder: the lowest-numbered pressed key wins. Scanning downward
  // lets the lower indices overwrite the higher ones.
  always_comb begin
    code_w = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (key_stable_q[i]) begin
        code_w = CODE_W'(i);
      end
    end
  end

  // Summary flags. Clearing the lowest set bit leaves a nonzero value only
  // when two or more keys are held.
  always_comb begin
    key_stable  = key_stable_q;
    key_press   = key_press_q;
    key_release = key_release_q;
    key_valid   = |key_stable_q;
    key_code    = code_w;
    multi_key   = |(key_stable_q & (key_stable_q - NKEYS'(1)));
  end

endmodule
`default_nettype wire
